// File: rtl/tm1638_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tm1638_pkg
// Description : Shared types and helpers for the TM1638 key-event path.
// Revision    : 1.0 - initial release
// ============================================================================
package tm1638_pkg;

  // Widest key index an event can carry (up to 256 keys).
  localparam int KEY_FIELD_W = 8;

  typedef struct packed {
    logic [KEY_FIELD_W-1:0] key;
    logic                   pressed;
  } key_event_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

  // Bits needed to index KEYS keys, never less than one.
  function automatic int key_index_w(input int keys);
    return (keys > 1) ? $clog2(keys) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. Head data is
//               driven straight from storage registers. A push into a full
//               FIFO is ignored even if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == COUNT_FULL);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tm1638_key_events.sv
`default_nettype none
// ============================================================================
// Module      : tm1638_key_events
// Description : Debounces TM1638 key-scan bytes on a fixed sample tick and
//               emits ordered press/release events through a FWFT queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tm1638_key_events
  import tm1638_pkg::*;
#(
  parameter int IN_COUNT         = 4,
  parameter int KEYS             = 8 * IN_COUNT,
  parameter int SAMPLE_DIV       = 250_000,
  parameter int DEBOUNCE_SAMPLES = 3,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IN_COUNT-1:0][7:0]      tm1638_in,
  output logic [KEYS-1:0]               keys_down,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [key_index_w(KEYS)-1:0]  ev_key,
  output logic                          ev_pressed,
  output logic                          ev_overflow,
  input  logic                          ev_clear
);

  localparam int KW = key_index_w(KEYS);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(SAMPLE_DIV - 1);
  localparam logic [3:0]    DEB_LAST    = 4'(DEBOUNCE_SAMPLES - 1);
  localparam logic [KW-1:0] IDX_LAST    = KW'(KEYS - 1);
  localparam logic [0:0]    ST_IDLE     = S_IDLE;
  localparam logic [0:0]    ST_SCAN     = S_SCAN;

  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [0:0]            state;
  logic [KW-1:0]         idx;
  logic [8*IN_COUNT-1:0] snap;
  logic [3:0]            deb_cnt [KEYS];
  logic                  cur_bit;
  logic                  differs;
  logic                  flip;
  logic                  fifo_full;
  logic                  fifo_empty;
  key_event_t            push_ev;
  key_event_t            head_ev;

  assign tick    = (tick_cnt == '0);
  assign cur_bit = snap[idx];
  assign differs = (state == ST_SCAN) && (cur_bit != keys_down[idx]);
  // The sample that completes the run flips the key and emits its event.
  assign flip    = differs && (deb_cnt[idx] == DEB_LAST);

  // Free-running sample divider: tick asserts for one cycle at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= TICK_RELOAD;
    end else if (tick) begin
      tick_cnt <= TICK_RELOAD;
    end else begin
      tick_cnt <= tick_cnt - 1'b1;
    end
  end

  // Snapshot on tick, then walk one key per clock updating its debounce run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      snap      <= '0;
      keys_down <= '0;
      for (int i = 0; i < KEYS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            snap  <= tm1638_in;
            idx   <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!differs) begin
            deb_cnt[idx] <= '0;
          end else if (flip) begin
            deb_cnt[idx]   <= '0;
            keys_down[idx] <= cur_bit;
          end else begin
            deb_cnt[idx] <= deb_cnt[idx] + 4'd1;
          end
          if (idx == IDX_LAST) begin
            state <= ST_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Build the event for the key currently being evaluated.
  always_comb begin
    push_ev         = '0;
    push_ev.key     = KEY_FIELD_W'(idx);
    push_ev.pressed = cur_bit;
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (flip),
    .push_data (push_ev),
    .full      (fifo_full),
    .pop       (ev_valid && ev_ready),
    .empty     (fifo_empty),
    .head_data (head_ev)
  );

  assign ev_valid   = !fifo_empty;
  assign ev_key     = head_ev.key[KW-1:0];
  assign ev_pressed = head_ev.pressed;

  if (KW < KEY_FIELD_W) begin : g_key_pad
    logic unused_key_pad;
    assign unused_key_pad = ^head_ev.key[KEY_FIELD_W-1:KW];
  end

  // Sticky drop flag; a same-cycle drop takes priority over clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_overflow <= 1'b0;
    end else if (flip && fifo_full) begin
      ev_overflow <= 1'b1;
    end else if (ev_clear) begin
      ev_overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tm1638_key_events.sv
`default_nettype none
// ============================================================================
// Module      : tb_tm1638_key_events
// Description : Self-checking bench for tm1638_key_events with a tick-level
//               reference model of debounce and event queue occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tm1638_key_events;

  localparam int DIV   = 40;
  localparam int DEB   = 3;
  localparam int DEPTH = 8;

  typedef struct {
    int at;
    int ev;
  } pend_t;

  logic             clk;
  logic             reset_n;
  logic [3:0][7:0]  tm_in;
  logic [31:0]      keys_down;
  logic             ev_valid;
  logic             ev_ready;
  logic [4:0]       ev_key;
  logic             ev_pressed;
  logic             ev_overflow;
  logic             ev_clear;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_kd;
  int          m_cnt [32];
  bit          m_ovf;
  int          exp_q[$];
  pend_t       pend[$];
  int          got_q[$];
  int          cyc;
  int          n_ev;
  int          run;
  int          max_run;
  bit          pop_flag;
  int          rdy_mode;

  tm1638_key_events #(
    .IN_COUNT         (4),
    .KEYS             (32),
    .SAMPLE_DIV       (DIV),
    .DEBOUNCE_SAMPLES (DEB),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tm1638_in   (tm_in),
    .keys_down   (keys_down),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_key      (ev_key),
    .ev_pressed  (ev_pressed),
    .ev_overflow (ev_overflow),
    .ev_clear    (ev_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // A sample latched at posedge T: key k changes state after the run of DEB
  // differing samples and its event enters the queue at posedge T+1+k.
  task automatic model_tick();
    logic [31:0] s;
    s = tm_in;
    for (int k = 0; k < 32; k++) begin
      if (s[k] == m_kd[k]) begin
        m_cnt[k] = 0;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == DEB) begin
          m_kd[k]  = s[k];
          m_cnt[k] = 0;
          pend.push_back('{at: cyc + 1 + k, ev: k * 2 + int'(s[k])});
        end
      end
    end
  endtask

  // Model clock: queue occupancy seen by a push is the pre-pop count.
  initial begin
    forever begin
      @(posedge clk);
      if (reset_n) begin
        cyc = cyc + 1;
        while (pend.size() != 0 && pend[0].at == cyc) begin
          if (exp_q.size() + int'(pop_flag) < DEPTH) exp_q.push_back(pend[0].ev);
          else m_ovf = 1'b1;
          void'(pend.pop_front());
        end
        pop_flag = 1'b0;
        if (cyc % DIV == 0) model_tick();
      end
    end
  end

  // Consumer and monitor: drive ready, compare popped events and state.
  initial begin
    forever begin
      @(negedge clk);
      if (rdy_mode == 2) ev_ready = 1'($urandom % 2);
      else               ev_ready = (rdy_mode == 1);
      if (reset_n) begin
        if (ev_valid) run = run + 1;
        else          run = 0;
        if (run > max_run) max_run = run;
        if (ev_valid && ev_ready) begin
          pop_flag = 1'b1;
          n_ev     = n_ev + 1;
          got_q.push_back({ev_key, ev_pressed});
          if (exp_q.size() == 0) check_eq("ev_unexpected", {ev_key, ev_pressed}, 32'hFFFF_FFFF);
          else                   check_eq("ev_order", {ev_key, ev_pressed}, exp_q.pop_front());
        end
        if (cyc > 0 && cyc % DIV == 35) begin
          check_eq("keys_down", keys_down, m_kd);
          check_eq("overflow", ev_overflow, m_ovf);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    cyc = 0;
    m_kd = '0;
    m_ovf = 1'b0;
    pop_flag = 1'b0;
    for (int k = 0; k < 32; k++) m_cnt[k] = 0;
    exp_q.delete();
    pend.delete();
    #1;
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_keys", keys_down, 0);
    check_eq("rst_ovf", ev_overflow, 0);
    check_eq("rst_key", ev_key, 0);
    check_eq("rst_pressed", ev_pressed, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_phase(input int p);
    do @(negedge clk); while (!(cyc > 0 && cyc % DIV == p));
  endtask

  // Let n ticks occur, then stop after the scan of the last one has finished.
  task automatic wait_ticks(input int n);
    repeat (n) wait_phase(0);
    wait_phase(35);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    rdy_mode = 1;
    while ((exp_q.size() != 0 || pend.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check_eq({tag, "_left"}, exp_q.size(), 0);
    check_eq({tag, "_valid"}, ev_valid, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] flat;
    tm_in    = '0;
    ev_clear = 1'b0;
    ev_ready = 1'b0;
    rdy_mode = 1;
    n_ev = 0; run = 0; max_run = 0;
    @(negedge clk);
    do_reset();

    // 1: press held five ticks, then released three ticks
    base = n_ev;
    tm_in[0] = 8'h20;
    wait_ticks(2);
    check_eq("s1_kd_tick2", keys_down[5], 0);
    wait_ticks(1);
    check_eq("s1_kd_tick3", keys_down[5], 1);
    wait_ticks(2);
    check_eq("s1_press_events", n_ev - base, 1);
    tm_in[0] = 8'h00;
    wait_ticks(3);
    check_eq("s1_kd_release", keys_down[5], 0);
    check_eq("s1_all_events", n_ev - base, 2);

    // 2: short bursts never reach the threshold and the run restarts
    base = n_ev;
    tm_in[0] = 8'h20; wait_ticks(2);
    tm_in[0] = 8'h00; wait_ticks(3);
    tm_in[0] = 8'h20; wait_ticks(2);
    tm_in[0] = 8'h00; wait_ticks(1);
    check_eq("s2_kd", keys_down, 0);
    check_eq("s2_events", n_ev - base, 0);

    // 3: simultaneous changes come out in ascending key order
    got_q.delete();
    tm_in[0] = 8'h01; tm_in[3] = 8'h01;
    wait_ticks(3);
    check_eq("s3_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check_eq("s3_first", got_q[0], 0 * 2 + 1);
      check_eq("s3_second", got_q[1], 24 * 2 + 1);
    end
    tm_in = '0;
    wait_ticks(3);
    drain("s3");

    // 4: nine changes with the consumer stalled overflow the queue
    rdy_mode = 0;
    @(negedge clk);
    tm_in[1] = 8'hFF; tm_in[2] = 8'h01;
    wait_ticks(3);
    check_eq("s4_ovf", ev_overflow, 1);
    check_eq("s4_head_key", ev_key, 8);
    check_eq("s4_head_pressed", ev_pressed, 1);
    @(negedge clk); ev_clear = 1'b1; m_ovf = 1'b0;
    @(negedge clk); ev_clear = 1'b0;
    #1 check_eq("s4_ovf_clear", ev_overflow, 0);
    base = n_ev;
    drain("s4");
    check_eq("s4_drained", n_ev - base, 8);
    tm_in = '0;
    wait_ticks(3);
    drain("s4_rel");

    // 5: reset in the middle of a scan with two events waiting
    rdy_mode = 0;
    @(negedge clk);
    tm_in[0] = 8'h03;
    wait_ticks(3);
    check_eq("s5_queued", ev_valid, 1);
    wait_phase(10);
    do_reset();
    wait_ticks(2);
    check_eq("s5_valid_tick2", ev_valid, 0);
    check_eq("s5_kd_tick2", keys_down, 0);
    wait_ticks(1);
    check_eq("s5_valid_tick3", ev_valid, 1);
    check_eq("s5_key_tick3", ev_key, 0);
    drain("s5");

    // 6: continuous ready, one new key per tick
    tm_in = '0;
    wait_ticks(3);
    drain("s6_pre");
    base = n_ev;
    max_run = 0;
    for (int i = 0; i < 6; i++) begin
      tm_in[1][i] = 1'b1;
      wait_ticks(1);
    end
    wait_ticks(3);
    check_eq("s6_pop_latency", max_run, 1);
    check_eq("s6_ovf", ev_overflow, 0);
    check_eq("s6_events", n_ev - base, 6);

    // random: toggle a few keys, hold for random spans, random consumer
    rdy_mode = 2;
    for (int it = 0; it < 14; it++) begin
      flat = tm_in;
      repeat ($urandom_range(1, 3)) flat[$urandom_range(0, 31)] ^= 1'b1;
      tm_in = flat;
      wait_ticks($urandom_range(1, 4));
    end
    tm_in = '0;
    wait_ticks(4);
    drain("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
